// File: rtl/packet_fifo.sv
// packet_fifo: store-and-forward packet buffer. A packet becomes visible at the
// output only once its last beat is stored, so the output stream never gaps
// mid-packet. Packets longer than the buffer are discarded whole and flagged.
module packet_fifo #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_DEPTH      = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic                       last_in,
  input  logic [P_DATA_WIDTH-1:0]    data_in,
  output logic                       ready_in,
  output logic                       valid_out,
  output logic                       last_out,
  output logic [P_DATA_WIDTH-1:0]    data_out,
  input  logic                       ready_out,
  output logic                       drop_out,
  output logic [$clog2(P_DEPTH):0]   level_out
);

  localparam int AW = $clog2(P_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] ONE      = PW'(1);
  localparam logic [PW-1:0] DEPTH    = PW'(P_DEPTH);
  localparam logic [PW-1:0] DEPTH_M1 = PW'(P_DEPTH - 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] DROP = 1'b1;

  logic [P_DATA_WIDTH:0] mem_q [P_DEPTH];

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] commit_q, commit_d;
  logic [PW-1:0] rd_q, rd_d;
  logic          ready_in_q, ready_in_d;
  logic          drop_q, drop_d;

  logic          mem_we;
  logic [P_DATA_WIDTH:0] mem_wdata;
  logic [PW-1:0] cur_len;
  logic [PW-1:0] level_next;
  logic          accept_in;
  logic          accept_out;

  assign ready_in  = ready_in_q;
  assign drop_out  = drop_q;
  assign level_out = wr_q - rd_q;
  assign valid_out = (rd_q != commit_q);
  assign {last_out, data_out} = mem_q[rd_q[AW-1:0]];

  // Next-state logic: write/commit/rewind on the input side, advance on output reads
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    commit_d   = commit_q;
    rd_d       = rd_q;
    drop_d     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = {last_in, data_in};
    cur_len    = wr_q - commit_q;
    accept_in  = valid_in && ready_in_q;
    accept_out = valid_out && ready_out;

    if (state_q == FILL) begin
      if (accept_in) begin
        if (!last_in && (cur_len == DEPTH_M1)) begin
          // Packet cannot fit: throw away what was written of it and swallow the rest
          wr_d    = commit_q;
          state_d = DROP;
        end else begin
          mem_we = rst_n;
          wr_d   = wr_q + ONE;
          if (last_in) begin
            commit_d = wr_q + ONE;
          end
        end
      end
    end else begin
      if (accept_in && last_in) begin
        state_d = FILL;
        drop_d  = 1'b1;
      end
    end

    if (accept_out) begin
      rd_d = rd_q + ONE;
    end

    level_next = wr_d - rd_d;
    ready_in_d = (state_d == DROP) || (level_next != DEPTH);
  end

  // Registered control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FILL;
      wr_q       <= '0;
      commit_q   <= '0;
      rd_q       <= '0;
      ready_in_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      commit_q   <= commit_d;
      rd_q       <= rd_d;
      ready_in_q <= ready_in_d;
      drop_q     <= drop_d;
    end
  end

  // Beat storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_q[AW-1:0]] <= mem_wdata;
    end
  end

endmodule
